// File: rtl/fm_fsk_ctrl_pkg.sv
// fm_fsk_ctrl_pkg
// Shared definitions for the FSK serialiser: FSM state encoding and the
// number of data bits carried in one UART-style frame.
package fm_fsk_ctrl_pkg;

    localparam int FM_DATA_BITS = 8;

    typedef enum logic [1:0] {
        FM_IDLE  = 2'd0,
        FM_START = 2'd1,
        FM_DATA  = 2'd2,
        FM_STOP  = 2'd3
    } fm_state_e;

endpackage

// File: rtl/fm_fsk_ctrl_baud_cnt.sv
// fm_fsk_ctrl_baud_cnt
// Symbol timer. Counts 0..p_baud_div-1 and flags the last cycle of each
// symbol; clearing on i_clr restarts a symbol.
// Ports:
//   i_clk   clock
//   i_nrst  synchronous active-low reset
//   i_clr   restart the symbol (counter to 0 next cycle)
//   o_tick  high on the last cycle of a symbol
module fm_fsk_ctrl_baud_cnt #(
    parameter int p_cnt_sz   = 16,
    parameter int p_baud_div = 1000
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [p_cnt_sz-1:0] LP_LAST = p_cnt_sz'(p_baud_div - 1);

    logic [p_cnt_sz-1:0] cnt_q;
    logic [p_cnt_sz-1:0] cnt_d;

    assign o_tick = (cnt_q == LP_LAST);

    always_comb begin
        cnt_d = cnt_q + p_cnt_sz'(1);
        if (i_clr || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fm_fsk_ctrl.sv
// fm_fsk_ctrl
// Serialises bytes into FSK symbols for the fm_tx phase accumulator.
// Frame per byte: start (space), 8 data bits LSB first (1=mark, 0=space),
// stop (mark). Each symbol lasts p_baud_div clocks. While idle the
// accumulator is held cleared via o_set.
//
// state    | meaning
// ---------+-------------------------------------------------------
// FM_IDLE  | no frame; o_set=1, ready for a byte
// FM_START | start symbol, shift = captured space
// FM_DATA  | data bits 0..7, shift = mark/space from shift register
// FM_STOP  | stop symbol (mark); last cycle may accept the next byte
//
// Ports:
//   i_clk, i_nrst           clock, synchronous active-low reset
//   i_data/i_valid/o_ready  byte source handshake
//   i_base_hz               carrier base frequency, captured on accept
//   i_mark_hz/i_space_hz    shift for mark/space, captured on accept
//   o_base_hz/o_shift_hz    frequency words to fm_tx
//   o_set                   high holds the fm_tx accumulator at 0
//   o_busy                  frame in progress
module fm_fsk_ctrl
    import fm_fsk_ctrl_pkg::*;
#(
    parameter int p_hz_sz    = 16,
    parameter int p_cnt_sz   = 16,
    parameter int p_baud_div = 1000
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic [7:0]         i_data,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [p_hz_sz-1:0] i_base_hz,
    input  logic [p_hz_sz-1:0] i_mark_hz,
    input  logic [p_hz_sz-1:0] i_space_hz,
    output logic [p_hz_sz-1:0] o_base_hz,
    output logic [p_hz_sz-1:0] o_shift_hz,
    output logic               o_set,
    output logic               o_busy
);

    localparam logic [2:0] LP_LAST_BIT = 3'(FM_DATA_BITS - 1);

    fm_state_e          state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic [2:0]         bit_q, bit_d;
    logic [p_hz_sz-1:0] base_q, base_d;
    logic [p_hz_sz-1:0] mark_q, mark_d;
    logic [p_hz_sz-1:0] space_q, space_d;
    logic [p_hz_sz-1:0] shift_q, shift_d;
    logic               set_q, set_d;
    logic               busy_q, busy_d;

    logic tick;
    logic accept;
    logic is_idle;

    assign is_idle = (state_q == FM_IDLE);
    assign o_ready = i_nrst & (is_idle | ((state_q == FM_STOP) & tick));
    assign accept  = i_valid & o_ready;

    // Held at 0 while idle so an accept always starts a full-length symbol.
    fm_fsk_ctrl_baud_cnt #(
        .p_cnt_sz  (p_cnt_sz),
        .p_baud_div(p_baud_div)
    ) u_baud_cnt (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .i_clr (accept | is_idle),
        .o_tick(tick)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bit_d   = bit_q;
        base_d  = base_q;
        mark_d  = mark_q;
        space_d = space_q;
        shift_d = shift_q;
        set_d   = set_q;

        case (state_q)
            FM_START: begin
                if (tick) begin
                    state_d = FM_DATA;
                    shift_d = data_q[0] ? mark_q : space_q;
                    data_d  = data_q >> 1;
                end
            end
            FM_DATA: begin
                if (tick) begin
                    if (bit_q == LP_LAST_BIT) begin
                        state_d = FM_STOP;
                        bit_d   = '0;
                        shift_d = mark_q;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = data_q[0] ? mark_q : space_q;
                        data_d  = data_q >> 1;
                    end
                end
            end
            FM_STOP: begin
                if (tick) begin
                    state_d = FM_IDLE;
                    set_d   = 1'b1;
                    shift_d = mark_q;
                end
            end
            default: ;
        endcase

        // Accept overrides the STOP->IDLE exit so back-to-back frames keep
        // o_set low and the phase continuous.
        if (accept) begin
            state_d = FM_START;
            data_d  = i_data;
            bit_d   = '0;
            base_d  = i_base_hz;
            mark_d  = i_mark_hz;
            space_d = i_space_hz;
            shift_d = i_space_hz;
            set_d   = 1'b0;
        end

        busy_d = (state_d != FM_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q <= FM_IDLE;
            data_q  <= '0;
            bit_q   <= '0;
            base_q  <= '0;
            mark_q  <= '0;
            space_q <= '0;
            shift_q <= '0;
            set_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            base_q  <= base_d;
            mark_q  <= mark_d;
            space_q <= space_d;
            shift_q <= shift_d;
            set_q   <= set_d;
            busy_q  <= busy_d;
        end
    end

    assign o_base_hz  = base_q;
    assign o_shift_hz = shift_q;
    assign o_set      = set_q;
    assign o_busy     = busy_q;

endmodule
